// File: rtl/slbi_pkg.sv
// Shared types and the result function for the SLBI execute unit.
// Defining SLBI_FLAGS_EN adds zero/negative/overflow flags to every entry.
package slbi_pkg;

    localparam int WIDTH_DEFAULT = 16;
    localparam int IMM_W         = WIDTH_DEFAULT / 2;

    typedef struct packed {
        logic [WIDTH_DEFAULT-1:0] data;
`ifdef SLBI_FLAGS_EN
        logic                     zf;
        logic                     nf;
        logic                     ovf;
`endif
    } slbi_entry_t;

    function automatic slbi_entry_t slbi_calc(
        input logic [WIDTH_DEFAULT-1:0] in1,
        input logic [WIDTH_DEFAULT-1:0] in2
    );
        slbi_entry_t e;
        logic        unused_hi;
        e         = '0;
        e.data    = {in1[IMM_W-1:0], in2[IMM_W-1:0]};
        // Upper halves only feed the overflow flag; the immediate's upper half is don't-care.
        unused_hi = ^{in1[WIDTH_DEFAULT-1:IMM_W], in2[WIDTH_DEFAULT-1:IMM_W]};
`ifdef SLBI_FLAGS_EN
        e.zf      = (e.data == '0);
        e.nf      = e.data[WIDTH_DEFAULT-1];
        e.ovf     = |in1[WIDTH_DEFAULT-1:IMM_W];
`endif
        return e;
    endfunction

endpackage

// File: rtl/slbi_skid.sv
// Generic 2-entry valid/ready skid buffer; out_* always comes from the main register
// and in_ready is purely registered (skid register empty).
module slbi_skid
    import slbi_pkg::*;
#(
    parameter type T = slbi_entry_t
) (
    input  logic clk,
    input  logic rst,
    input  T     in_data,
    input  logic in_valid,
    output logic in_ready,
    output T     out_data,
    output logic out_valid,
    input  logic out_ready
);

    T     main_q;
    T     skid_q;
    logic main_v;
    logic skid_v;
    logic push;
    logic pop;
    logic main_load;

    assign push      = in_valid && !skid_v;
    assign pop       = main_v && out_ready;
    assign main_load = pop || !main_v;

    assign in_ready  = !skid_v;
    assign out_data  = main_q;
    assign out_valid = main_v;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_q <= '0;
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (main_load) begin
            if (skid_v) begin
                main_q <= skid_q;
                main_v <= 1'b1;
                skid_v <= 1'b0;
            end else begin
                main_v <= push;
                if (push) begin
                    main_q <= in_data;
                end
            end
        end else if (push) begin
            skid_v <= 1'b1;
        end
    end

    // NOTE: skid data needs no reset; it is only observed once skid_v marks it valid.
    always_ff @(posedge clk) begin
        if (push && !main_load) begin
            skid_q <= in_data;
        end
    end

endmodule

// File: rtl/slbi_unit.sv
// Execute-stage SLBI unit: out = {in1[W/2-1:0], in2[W/2-1:0]}, registered behind a skid buffer.
// Defining SLBI_FLAGS_EN adds registered zf/nf/ovf outputs that travel with the data.
module slbi_unit
    import slbi_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready
`ifdef SLBI_FLAGS_EN
    ,
    output logic             zf,
    output logic             nf,
    output logic             ovf
`endif
);

    localparam int HALF = WIDTH / 2;

    typedef struct packed {
        logic [WIDTH-1:0] data;
`ifdef SLBI_FLAGS_EN
        logic             zf;
        logic             nf;
        logic             ovf;
`endif
    } entry_t;

    entry_t res;
    entry_t head;

    if (WIDTH == WIDTH_DEFAULT) begin : g_pkg_calc
        assign res = slbi_calc(in1, in2);
    end else begin : g_wide_calc
        logic unused_hi;
        assign unused_hi = ^{in1[WIDTH-1:HALF], in2[WIDTH-1:HALF]};

        // NOTE: default-assign the whole struct first so no field can infer a latch.
        always_comb begin
            res      = '0;
            res.data = {in1[HALF-1:0], in2[HALF-1:0]};
`ifdef SLBI_FLAGS_EN
            res.zf   = (res.data == '0);
            res.nf   = res.data[WIDTH-1];
            res.ovf  = |in1[WIDTH-1:HALF];
`endif
        end
    end

    slbi_skid #(
        .T(entry_t)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_data  (res),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (head),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    assign out = head.data;
`ifdef SLBI_FLAGS_EN
    assign zf  = head.zf;
    assign nf  = head.nf;
    assign ovf = head.ovf;
`endif

endmodule

// File: tb/tb_slbi_unit.sv
// Self-checking bench for slbi_unit: directed vectors plus randomized traffic against a FIFO model.
`timescale 1ns/1ps
module tb_slbi_unit;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out;
    logic         out_valid;
    logic         out_ready;
`ifdef SLBI_FLAGS_EN
    logic         zf;
    logic         nf;
    logic         ovf;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [W-1:0] data;
        logic         ovf;
    } exp_t;

    exp_t exp_q[$];

    slbi_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in1      (in1),
        .in2      (in2),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out      (out),
        .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef SLBI_FLAGS_EN
        ,
        .zf       (zf),
        .nf       (nf),
        .ovf      (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: low byte of in1 times 256 plus low byte of in2; overflow if in1 >= 256.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        int unsigned hi;
        int unsigned lo;
        hi     = int'(a) % 256;
        lo     = int'(b) % 256;
        e.data = W'(hi * 256 + lo);
        e.ovf  = (int'(a) >= 256);
        return e;
    endfunction

    task automatic test_reset();
        int spurious;
        rst       = 1'b0;
        in_valid  = 1'b1;
        in1       = 16'hABCD;
        in2       = 16'h1234;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (out !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_out: got %h expected 0000", out);
        end
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
`ifdef SLBI_FLAGS_EN
        tests_run++;
        if ({zf, nf, ovf} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b expected 000", {zf, nf, ovf});
        end
`endif
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        spurious = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid !== 1'b0) spurious++;
        end
        tests_run++;
        if (spurious != 0) begin
            tests_failed++;
            $display("FAIL reset_release_spurious: got %0d valid cycles expected 0", spurious);
        end
    endtask

    task automatic test_vectors();
        logic [W-1:0] v_a  [3] = '{16'h1234, 16'h0100, 16'h0080};
        logic [W-1:0] v_b  [3] = '{16'hFF56, 16'h0000, 16'h0001};
        logic [W-1:0] v_res[3] = '{16'h3456, 16'h0000, 16'h8001};
        logic [2:0]   v_flg[3] = '{3'b001, 3'b101, 3'b010};  // {zf, nf, ovf}
        for (int r = 0; r < 3; r++) begin
            @(posedge clk);
            #1;
            in1       = v_a[r];
            in2       = v_b[r];
            in_valid  = 1'b1;
            out_ready = 1'b1;
            @(negedge clk);
            tests_run++;
            if (in_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL vec%0d_in_ready: got %b expected 1", r, in_ready);
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            @(negedge clk);
            tests_run++;
            if (out_valid !== 1'b1 || out !== v_res[r]) begin
                tests_failed++;
                $display("FAIL vec%0d_out: got valid=%b out=%h expected valid=1 out=%h",
                         r, out_valid, out, v_res[r]);
            end
`ifdef SLBI_FLAGS_EN
            tests_run++;
            if ({zf, nf, ovf} !== v_flg[r]) begin
                tests_failed++;
                $display("FAIL vec%0d_flags: got %b expected %b", r, {zf, nf, ovf}, v_flg[r]);
            end
`else
            if (v_flg[r] === 3'bxxx) $display("unreachable");
`endif
            @(negedge clk);
            tests_run++;
            if (out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL vec%0d_drained: got valid=%b expected 0", r, out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a  [3];
        logic [W-1:0] b  [3];
        exp_t         e  [3];
        logic [W-1:0] got[$];
        int           held_ready_bad;
        int           held_out_bad;
        int           first;
        int           last;
        logic         accepting;
        for (int i = 0; i < 3; i++) begin
            a[i] = W'($urandom);
            b[i] = W'($urandom);
            e[i] = model(a[i], b[i]);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in1       = a[0];
        in2       = b[0];
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in1 = a[1];
        in2 = b[1];
        @(posedge clk);
        #1;
        in1 = a[2];
        in2 = b[2];
        held_ready_bad = 0;
        held_out_bad   = 0;
        repeat (3) begin
            @(negedge clk);
            if (in_ready !== 1'b0) held_ready_bad++;
            if (out_valid !== 1'b1 || out !== e[0].data) held_out_bad++;
        end
        tests_run++;
        if (held_ready_bad != 0) begin
            tests_failed++;
            $display("FAIL bp_in_ready_low: got %0d cycles with in_ready!=0 expected 0", held_ready_bad);
        end
        tests_run++;
        if (held_out_bad != 0) begin
            tests_failed++;
            $display("FAIL bp_hold_head: got %0d bad cycles (out=%h) expected 0, head %h",
                     held_out_bad, out, e[0].data);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        first     = -1;
        last      = -1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                got.push_back(out);
                if (first < 0) first = c;
                last = c;
            end
            accepting = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (accepting) in_valid = 1'b0;
        end
        tests_run++;
        if (got.size() != 3) begin
            tests_failed++;
            $display("FAIL bp_count: got %0d results expected 3", got.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests_run++;
                if (got[i] !== e[i].data) begin
                    tests_failed++;
                    $display("FAIL bp_order%0d: got %h expected %h", i, got[i], e[i].data);
                end
            end
            tests_run++;
            if (last - first != 2) begin
                tests_failed++;
                $display("FAIL bp_rate: got %0d cycles for 3 results expected 3", last - first + 1);
            end
        end
    endtask

    task automatic test_streaming();
        int   pops;
        int   stalls;
        exp_t e;
        exp_q.delete();
        pops   = 0;
        stalls = 0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 202; i++) begin
            if (i < 200) begin
                in1      = W'($urandom);
                in2      = W'($urandom);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (out_valid && out_ready) begin
                pops++;
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL stream_spurious: got %h expected no output", out);
                end else begin
                    e = exp_q.pop_front();
                    if (out !== e.data) begin
                        tests_failed++;
                        $display("FAIL stream_data: got %h expected %h", out, e.data);
                    end
`ifdef SLBI_FLAGS_EN
                    tests_run++;
                    if ({zf, nf, ovf} !== {e.data == 16'h0000, e.data >= 16'h8000, e.ovf}) begin
                        tests_failed++;
                        $display("FAIL stream_flags: got %b for data %h", {zf, nf, ovf}, e.data);
                    end
`endif
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(in1, in2));
            else if (i < 200) stalls++;
            @(posedge clk);
            #1;
        end
        tests_run++;
        if (pops != 200 || stalls != 0) begin
            tests_failed++;
            $display("FAIL stream_throughput: got %0d results %0d stalls expected 200 and 0", pops, stalls);
        end
    endtask

    task automatic test_random_handshake();
        exp_t e;
        exp_q.delete();
        for (int i = 0; i < 300; i++) begin
            in1       = W'($urandom);
            in2       = W'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            tests_run++;
            if (in_ready !== (exp_q.size() < 2)) begin
                tests_failed++;
                $display("FAIL rand_in_ready: got %b with %0d held expected %b",
                         in_ready, exp_q.size(), exp_q.size() < 2);
            end
            tests_run++;
            if (out_valid !== (exp_q.size() > 0)) begin
                tests_failed++;
                $display("FAIL rand_out_valid: got %b with %0d held", out_valid, exp_q.size());
            end
            if (out_valid && out_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests_run++;
                if (out !== e.data) begin
                    tests_failed++;
                    $display("FAIL rand_data: got %h expected %h", out, e.data);
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(in1, in2));
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests_run++;
                if (out !== e.data) begin
                    tests_failed++;
                    $display("FAIL rand_drain_data: got %h expected %h", out, e.data);
                end
            end
            @(posedge clk);
            #1;
        end
        tests_run++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rand_lost: got %0d undelivered, out_valid=%b expected 0 and 0",
                     exp_q.size(), out_valid);
        end
    endtask

    task automatic test_reset_midstream();
        int   stale;
        exp_t e;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in1       = W'($urandom);
        in2       = W'($urandom);
        @(posedge clk);
        #1;
        in1 = W'($urandom);
        in2 = W'($urandom);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_full: got in_ready=%b out_valid=%b expected 0 and 1", in_ready, out_valid);
        end
        #2;
        rst = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || out !== 16'h0000 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_immediate: got valid=%b out=%h in_ready=%b expected 0 0000 1",
                     out_valid, out, in_ready);
        end
        @(posedge clk);
        #2;
        rst       = 1'b1;
        out_ready = 1'b1;
        stale     = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stale++;
        end
        tests_run++;
        if (stale != 0) begin
            tests_failed++;
            $display("FAIL midrst_stale: got %0d valid cycles expected 0", stale);
        end
        @(posedge clk);
        #1;
        in1      = W'($urandom);
        in2      = W'($urandom);
        e        = model(in1, in2);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b1 || out !== e.data) begin
            tests_failed++;
            $display("FAIL midrst_first: got valid=%b out=%h expected 1 %h", out_valid, out, e.data);
        end
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_no_dup: got valid=%b out=%h expected 0", out_valid, out);
        end
    endtask

    initial begin
        rst       = 1'b0;
        in1       = '0;
        in2       = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_vectors();
        test_backpressure();
        test_streaming();
        test_random_handshake();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
